// File: rtl/data_receiver_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : data_receiver_pkg
// Brief   : Shared frame constants and FSM encodings (DATA_RECEIVER_TIMEOUT_EN adds ST_DRAIN)
// Revision: 1.0
// ----------------------------------------------------------------------------
package data_receiver_pkg;

  localparam int unsigned c_frame_width    = 64;
  localparam int unsigned c_timeout_cycles = 1000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECEIVE = 2'd1
`ifdef DATA_RECEIVER_TIMEOUT_EN
    ,
    ST_DRAIN   = 2'd2
`endif
  } state_t;

endpackage
`default_nettype wire

// File: rtl/data_receiver_line_synchronizer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : data_receiver_line_synchronizer
// Brief   : 2-FF synchroniser plus history FF for one link line; level/rise/fall
// Revision: 1.0
// ----------------------------------------------------------------------------
module data_receiver_line_synchronizer (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic level,
  output logic rise,
  output logic fall
);

  logic       r_s1;
  logic       r_s2;
  logic       r_s3;
  logic [1:0] r_fill;
  logic       w_primed;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_s3   <= 1'b0;
      r_fill <= 2'd0;
    end else begin
      r_s1 <= line;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      if (r_fill != 2'd3) begin
        r_fill <= r_fill + 2'd1;
      end
    end
  end

  // Edges are masked until the pipe holds real samples, so a line already
  // high when reset releases is not mistaken for a rising edge.
  assign w_primed = (r_fill == 2'd3);
  assign level    = r_s2;
  assign rise     = w_primed & r_s2 & ~r_s3;
  assign fall     = w_primed & ~r_s2 & r_s3;

endmodule
`default_nettype wire

// File: rtl/data_receiver.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : data_receiver
// Brief   : Three-wire serial link receiver, MSB-first WIDTH-bit frames; optional
//           stall timeout under DATA_RECEIVER_TIMEOUT_EN
// Revision: 1.0
// ----------------------------------------------------------------------------
module data_receiver
  import data_receiver_pkg::*;
#(
  parameter int unsigned WIDTH          = c_frame_width,
  parameter int unsigned TIMEOUT_CYCLES = c_timeout_cycles
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             transmission,
  input  logic             clock,
  input  logic             data,
  output logic [WIDTH-1:0] out_data,
  output logic             valid,
  output logic             busy,
  output logic             frame_error
);

  localparam int unsigned c_count_w = $clog2(WIDTH + 2);
  localparam logic [c_count_w-1:0] c_count_one  = c_count_w'(1);
  localparam logic [c_count_w-1:0] c_count_full = c_count_w'(WIDTH);
  localparam logic [c_count_w-1:0] c_count_max  = c_count_w'(WIDTH + 1);

  logic [2:0] w_line;
  logic [2:0] w_level;
  logic [2:0] w_rise;
  logic [2:0] w_fall;
  logic       w_unused;

  assign w_line = {transmission, clock, data};

  for (genvar gi = 0; gi < 3; gi++) begin : g_sync
    data_receiver_line_synchronizer u_sync (
      .clk   (clk),
      .rst   (rst),
      .line  (w_line[gi]),
      .level (w_level[gi]),
      .rise  (w_rise[gi]),
      .fall  (w_fall[gi])
    );
  end

  logic w_tx_rise;
  logic w_tx_fall;
  logic w_clk_rise;
  logic w_data;

  assign w_tx_rise  = w_rise[2];
  assign w_tx_fall  = w_fall[2];
  assign w_clk_rise = w_rise[1];
  assign w_data     = w_level[0];
  assign w_unused   = &{1'b0, w_level[2:1], w_rise[0], w_fall[1:0]};

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH-1:0]     r_shift;
  logic [WIDTH-1:0]     w_shift_nxt;
  logic [c_count_w-1:0] r_count;
  logic [c_count_w-1:0] w_count_nxt;
  logic [WIDTH-1:0]     r_out_data;
  logic [WIDTH-1:0]     w_out_nxt;
  logic                 r_valid;
  logic                 w_valid_nxt;
  logic                 r_frame_error;
  logic                 w_error_nxt;

`ifdef DATA_RECEIVER_TIMEOUT_EN
  localparam int unsigned c_timer_w = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_timer_w-1:0] c_timer_limit = c_timer_w'(TIMEOUT_CYCLES);

  logic [c_timer_w-1:0] r_timer;
  logic [c_timer_w-1:0] w_timer_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_timer <= '0;
    end else begin
      r_timer <= w_timer_nxt;
    end
  end
`else
  localparam int unsigned c_unused_timeout = TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_shift       <= '0;
      r_count       <= '0;
      r_out_data    <= '0;
      r_valid       <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_shift       <= w_shift_nxt;
      r_count       <= w_count_nxt;
      r_out_data    <= w_out_nxt;
      r_valid       <= w_valid_nxt;
      r_frame_error <= w_error_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_count_nxt = r_count;
    w_out_nxt   = r_out_data;
    w_valid_nxt = 1'b0;
    w_error_nxt = 1'b0;
`ifdef DATA_RECEIVER_TIMEOUT_EN
    w_timer_nxt = '0;
`endif
    case (r_state)
      ST_IDLE: begin
        // A bit clock edge coincident with frame start is taken as bit 0.
        if (w_tx_rise) begin
          w_state_nxt = ST_RECEIVE;
          w_shift_nxt = w_clk_rise ? {{(WIDTH-1){1'b0}}, w_data} : '0;
          w_count_nxt = w_clk_rise ? c_count_one : '0;
        end
      end
      ST_RECEIVE: begin
        if (w_clk_rise) begin
          w_shift_nxt = {r_shift[WIDTH-2:0], w_data};
          w_count_nxt = (r_count == c_count_max) ? r_count : r_count + 1'b1;
        end
        // The length check sees a bit arriving in the same cycle as frame end.
        if (w_tx_fall) begin
          w_state_nxt = ST_IDLE;
          if (w_count_nxt == c_count_full) begin
            w_out_nxt   = w_shift_nxt;
            w_valid_nxt = 1'b1;
          end else begin
            w_error_nxt = 1'b1;
          end
        end
`ifdef DATA_RECEIVER_TIMEOUT_EN
        else begin
          w_timer_nxt = w_clk_rise ? '0 : r_timer + 1'b1;
          if (w_timer_nxt == c_timer_limit) begin
            w_error_nxt = 1'b1;
            w_state_nxt = ST_DRAIN;
          end
        end
`endif
      end
`ifdef DATA_RECEIVER_TIMEOUT_EN
      ST_DRAIN: begin
        if (w_tx_fall) begin
          w_state_nxt = ST_IDLE;
        end
      end
`endif
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign out_data    = r_out_data;
  assign valid       = r_valid;
  assign frame_error = r_frame_error;
  assign busy        = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_data_receiver.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : tb_data_receiver
// Brief   : Bench for data_receiver; timeout case needs DATA_RECEIVER_TIMEOUT_EN
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_data_receiver;

  localparam int W = 64;
  localparam int H = 3;  // link half bit period in clk cycles

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         transmission = 1'b0;
  logic         clock = 1'b0;
  logic         data = 1'b0;
  logic [W-1:0] out_data;
  logic         valid;
  logic         busy;
  logic         frame_error;

  data_receiver #(.WIDTH(W), .TIMEOUT_CYCLES(50)) dut (
    .clk          (clk),
    .rst          (rst),
    .transmission (transmission),
    .clock        (clock),
    .data         (data),
    .out_data     (out_data),
    .valid        (valid),
    .busy         (busy),
    .frame_error  (frame_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           is_valid;
    logic [W-1:0] word;
  } exp_t;

  typedef struct {
    logic [71:0]  word;
    int           nbits;
    bit           same_start;
    bit           same_end;
    int           gap;
    bit           exp_valid;
    logic [W-1:0] exp_out;
  } vec_t;

  exp_t         sb[$];
  vec_t         vecs[7];
  int           n_cmp = 0;
  int           n_err = 0;
  logic [W-1:0] last_good = '0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    check(name, {{(W-1){1'b0}}, act}, {{(W-1){1'b0}}, exp});
  endtask

  task automatic push_exp(input bit v, input logic [W-1:0] w);
    exp_t e;
    e.is_valid = v;
    e.word     = w;
    sb.push_back(e);
    if (v) last_good = w;
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_phase(input logic b, input bit raise_tx, input bit drop_tx);
    data = b;
    wait_clk(H);
    clock = 1'b1;
    if (raise_tx) transmission = 1'b1;
    if (drop_tx)  transmission = 1'b0;
    wait_clk(H);
    clock = 1'b0;
  endtask

  task automatic send_frame(input logic [71:0] word, input int nbits,
                            input bit same_start, input bit same_end);
    if (!same_start) begin
      transmission = 1'b1;
      wait_clk(H);
    end
    for (int i = nbits - 1; i >= 0; i--) begin
      bit_phase(word[i], same_start && (i == nbits - 1), same_end && (i == 0));
      if (i == nbits - 11) check_bit("busy_mid_frame", busy, 1'b1);
    end
    if (!same_end) begin
      wait_clk(H);
      transmission = 1'b0;
    end
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 50 && sb.size() != 0; c++) wait_clk(1);
    check("scoreboard_drained", W'(sb.size()), '0);
  endtask

  // Scoreboard: every valid/frame_error pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst && (valid || frame_error)) begin
      check_bit("pulse_exclusive", valid & frame_error, 1'b0);
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_pulse: actual valid=%b frame_error=%b required none", valid, frame_error);
      end else begin
        e = sb.pop_front();
        check_bit("pulse_kind_valid", valid, e.is_valid);
        check("out_data", out_data, e.word);
        if (valid) check_bit("busy_after_valid", busy, 1'b0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    bit seen;

    vecs[0] = '{72'h00_DEADBEEF_01234567, 64, 1'b0, 1'b0, 10, 1'b1, 64'hDEADBEEF_01234567};
    vecs[1] = '{72'h00_00000000_00000001, 64, 1'b0, 1'b0, 10, 1'b1, 64'h00000000_00000001};
    vecs[2] = '{72'h00_12345678_9ABCDEF0, 63, 1'b0, 1'b0, 10, 1'b0, 64'h00000000_00000001};
    vecs[3] = '{72'h01_FFFF0000_FFFF0000, 65, 1'b0, 1'b0, 10, 1'b0, 64'h00000000_00000001};
    vecs[4] = '{72'h00_00000000_00000000, 64, 1'b0, 1'b0,  4, 1'b1, 64'h00000000_00000000};
    vecs[5] = '{72'h00_FFFFFFFF_FFFFFFFF, 64, 1'b0, 1'b0, 10, 1'b1, 64'hFFFFFFFF_FFFFFFFF};
    vecs[6] = '{72'h00_80000000_00000001, 64, 1'b1, 1'b1, 10, 1'b1, 64'h80000000_00000001};

    // Reset state, with transmission already high across reset release.
    transmission = 1'b1;
    wait_clk(4);
    check("reset_out_data", out_data, '0);
    check_bit("reset_valid", valid, 1'b0);
    check_bit("reset_busy", busy, 1'b0);
    check_bit("reset_frame_error", frame_error, 1'b0);
    rst = 1'b1;
    wait_clk(10);
    check_bit("tx_high_at_release_busy", busy, 1'b0);
    for (int b = 0; b < 4; b++) bit_phase(b[0], 1'b0, 1'b0);
    transmission = 1'b0;
    wait_clk(10);
    check_bit("tx_high_at_release_idle", busy, 1'b0);

    foreach (vecs[k]) begin
      push_exp(vecs[k].exp_valid, vecs[k].exp_out);
      send_frame(vecs[k].word, vecs[k].nbits, vecs[k].same_start, vecs[k].same_end);
      wait_clk(vecs[k].gap);
    end
    wait_drain();

    // Reset in the middle of a frame.
    transmission = 1'b1;
    wait_clk(H);
    for (int b = 0; b < 30; b++) bit_phase(b[0], 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    check("midreset_out_data", out_data, '0);
    check_bit("midreset_busy", busy, 1'b0);
    check_bit("midreset_valid", valid, 1'b0);
    check_bit("midreset_frame_error", frame_error, 1'b0);
    transmission = 1'b0;
    last_good = '0;
    wait_clk(5);
    rst = 1'b1;
    wait_clk(20);
    check_bit("after_midreset_busy", busy, 1'b0);
    push_exp(1'b1, 64'hA5A5_A5A5_A5A5_A5A5);
    send_frame({8'h00, 64'hA5A5_A5A5_A5A5_A5A5}, 64, 1'b0, 1'b0);
    wait_clk(10);
    wait_drain();

`ifdef DATA_RECEIVER_TIMEOUT_EN
    // Stalled bit clock: timeout error, DRAIN holds busy until frame end.
    push_exp(1'b0, last_good);
    transmission = 1'b1;
    wait_clk(H);
    for (int b = 0; b < 10; b++) bit_phase(b[0], 1'b0, 1'b0);
    lat  = H;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      wait_clk(1);
      lat++;
      if (frame_error) seen = 1'b1;
    end
    check_bit("timeout_seen", seen, 1'b1);
    check_bit("timeout_latency_window", (lat >= 50) && (lat <= 56), 1'b1);
    wait_clk(20);
    check_bit("drain_busy", busy, 1'b1);
    transmission = 1'b0;
    wait_clk(1);
    check_bit("drain_busy_after_fall_1", busy, 1'b1);
    wait_clk(2);
    check_bit("drain_busy_after_fall_3", busy, 1'b0);
    wait_clk(10);
    wait_drain();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
